axis_quad_splitter: RTL
=======================

# axis_quad_splitter

Return-path counterpart to the quad adder. Accepts one 256-bit AXI-Stream of sixteen signed 16-bit samples from the DMA MM2S channel. Deinterleaves the samples round-robin onto four 128-bit AXI-Stream outputs (m00, m01, m20, m21), each carrying sixteen signed 8-bit samples. Each 16-bit sample is shifted and saturated to 8 bits, and four input beats are packed into one output beat per channel.

## Interface
- SDATA_WIDTH, 256: input tdata width (16 samples × 16 bits).
- MDATA_WIDTH, 128: per-output tdata width (16 samples × 8 bits).
- SHIFT, 0: arithmetic right shift applied to each 16-bit sample before saturation; legal values 0..8.
- CLK  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- s_axis_mm2s_tdata  in  256  sample i = bits [16i+15:16i], i = 0..15.
- s_axis_mm2s_tvalid  in  1  input valid.
- s_axis_mm2s_tready  out  1  input ready.
- s_axis_mm2s_tlast  in  1  end of packet.
- mXX_axis_tdata  out  128  for XX ∈ {00, 01, 20, 21}; channel index c = 0, 1, 2, 3 respectively.
- mXX_axis_tkeep  out  16  byte-valid mask.
- mXX_axis_tvalid  out  1  output valid.
- mXX_axis_tready  in  1  consumer ready.
- mXX_axis_tlast  out  1  end of packet.
- sat_clear  in  1  one-cycle pulse; clears sat_flag.
- sat_flag  out  4  sticky saturation flag, bit c = channel c.

## Operation
- Input tkeep is not present; all input bytes are valid on every beat.
- Conversion per sample:
  - t = sample >>> SHIFT (signed).
  - Result = 127 if t > 127; −128 if t < −128; otherwise t[7:0].
  - Any clamp sets sat_flag[c] for the owning channel.
  - sat_clear has priority over a same-cycle set.
- Deinterleave: channel c takes input samples c, c+4, c+8, c+12 as j = 0..3.
- Packing:
  - Shared pack counter cnt (0..3) advances on each accepted input beat.
  - Converted sample j goes to byte lane 4·cnt + j of channel c's pack register.
- Word completion: an accepted beat with cnt == 3 or tlast == 1 completes a word.
  - tkeep = lower 4·(cnt+1) bytes set; unused upper bytes are 0.
  - tlast = input tlast.
  - cnt returns to 0.
- Holding registers:
  - Each channel has one holding register that drives its mXX outputs.
  - A completed word loads all four holding registers together, and only when all four mXX_axis_tvalid are low ("all_free").
  - Each channel drains independently: mXX_axis_tvalid clears on mXX_axis_tvalid && mXX_axis_tready.
- FSM:
  - FILL: s_axis_mm2s_tready = 1.
    - On a completing beat with all_free: load holding, stay in FILL.
    - On a completing beat without all_free: keep the word in the pack registers, go to WAIT.
  - WAIT: s_axis_mm2s_tready = 0.
    - When all_free: load holding from the pack registers, go to FILL.
- A non-completing beat never stalls, even while outputs are busy.
- s_axis_mm2s_tready is a pure function of FSM state; there is no combinational path from any mXX_axis_tready.

## Timing
- Reset (resetn low at a rising edge):
  - All mXX tdata, tkeep, tvalid, tlast = 0.
  - sat_flag = 0; cnt = 0; pack registers cleared.
  - FSM = FILL; s_axis_mm2s_tready = 0 while resetn is low.
- First edge after resetn rises: s_axis_mm2s_tready = 1.
- Reset mid-packet discards the partial word and any pending holding data without emitting them.
- Latency: completing beat accepted at edge N → mXX_axis_tvalid = 1 from edge N (visible in cycle N+1), all four channels simultaneously.
- WAIT exit: the last drain handshake at edge M → holding loaded at edge M+1 → tready = 1 after edge M+1.
- Sustained throughput with all consumers always ready: one input beat per cycle, no bubbles.
- Outputs obey AXI-Stream:
  - tdata, tkeep, tlast are stable while tvalid && !tready.
  - tvalid never drops without a handshake.

## Test plan
- Ramp, SHIFT=0, all ready:
  - Stimulus: 4 beats, sample i of beat b = 4b + i/4 (small positive values); tlast on beat 3.
  - Required: one word per channel, 1 cycle after beat 3.
  - m00 byte lane 4b+j = 4b+j, i.e. tdata = 128'h0F0E…0100.
  - tkeep = 16'hFFFF, tlast = 1, sat_flag = 0.
- Saturation, SHIFT=0:
  - Stimulus: sample0 = 16'h0100, sample1 = 16'hFE00, sample2 = 16'h007F.
  - Required: m00 byte0 = 8'h7F, m01 byte0 = 8'h80, m20 byte0 = 8'h7F; sat_flag = 4'b0011.
  - A sat_clear pulse → sat_flag = 0.
- Short packet:
  - Stimulus: tlast on the 2nd beat (cnt = 1).
  - Required: all channels tkeep = 16'h00FF, tlast = 1, bytes 8..15 = 0.
  - The following beat packs into lane 0 (cnt restarted at 0).
- Backpressure:
  - Stimulus: m20_axis_tready held low; 8 beats offered back-to-back.
  - Required: m00, m01, m21 drain word 1; beats 5..8 accepted; FSM enters WAIT with s_axis_mm2s_tready = 0.
  - Releasing m20 → word 2 appears on all channels 1 cycle after m20's handshake; data intact and in order.
- Reset mid-packet:
  - Stimulus: 2 beats accepted, then resetn low for 1 cycle.
  - Required: all outputs 0, tready = 0 during reset.
  - The next 4 beats produce a clean word containing no pre-reset data.

Source files
------------

// File: rtl/axis_quad_splitter.sv
// Splits one 256-bit stream of sixteen s16 samples round-robin onto four 128-bit streams of s8 samples.
// Latency: a completing input beat accepted at edge N shows on all four outputs from edge N.
// Backpressure: input stalls (tready=0) only when a word completes while any output still holds data.
//
// Ports:
//   CLK, resetn                   clock, synchronous active-low reset
//   s_axis_mm2s_*                 256-bit input stream (tdata/tvalid/tready/tlast), no tkeep
//   m00/m01/m20/m21_axis_*        128-bit output streams, channel c = 0..3 (tdata/tkeep/tvalid/tready/tlast)
//   sat_clear, sat_flag           clear pulse and sticky per-channel saturation flags
module axis_quad_splitter #(
    parameter int SDATA_WIDTH = 256,
    parameter int MDATA_WIDTH = 128,
    parameter int SHIFT       = 0
) (
    input  logic                     CLK,
    input  logic                     resetn,

    input  logic [SDATA_WIDTH-1:0]   s_axis_mm2s_tdata,
    input  logic                     s_axis_mm2s_tvalid,
    output logic                     s_axis_mm2s_tready,
    input  logic                     s_axis_mm2s_tlast,

    output logic [MDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [MDATA_WIDTH/8-1:0] m00_axis_tkeep,
    output logic                     m00_axis_tvalid,
    input  logic                     m00_axis_tready,
    output logic                     m00_axis_tlast,

    output logic [MDATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [MDATA_WIDTH/8-1:0] m01_axis_tkeep,
    output logic                     m01_axis_tvalid,
    input  logic                     m01_axis_tready,
    output logic                     m01_axis_tlast,

    output logic [MDATA_WIDTH-1:0]   m20_axis_tdata,
    output logic [MDATA_WIDTH/8-1:0] m20_axis_tkeep,
    output logic                     m20_axis_tvalid,
    input  logic                     m20_axis_tready,
    output logic                     m20_axis_tlast,

    output logic [MDATA_WIDTH-1:0]   m21_axis_tdata,
    output logic [MDATA_WIDTH/8-1:0] m21_axis_tkeep,
    output logic                     m21_axis_tvalid,
    input  logic                     m21_axis_tready,
    output logic                     m21_axis_tlast,

    input  logic                     sat_clear,
    output logic [3:0]               sat_flag
);

    localparam int NCH   = 4;
    localparam int LANES = MDATA_WIDTH / 8;

    typedef enum logic {ST_FILL, ST_WAIT} state_t;

    state_t                  state;
    logic                    s_ready_q;
    logic [1:0]              cnt;
    logic [MDATA_WIDTH-1:0]  pack      [NCH];
    logic [LANES-1:0]        pend_keep;
    logic                    pend_last;

    logic [MDATA_WIDTH-1:0]  hold_dat  [NCH];
    logic [LANES-1:0]        hold_keep [NCH];
    logic                    hold_last [NCH];
    logic [NCH-1:0]          hold_vld;

    logic [NCH-1:0]          m_rdy;
    logic [MDATA_WIDTH-1:0]  word      [NCH];
    logic [LANES-1:0]        keep_new;
    logic [NCH-1:0]          sat_hit;
    logic                    beat_acc;
    logic                    word_done;
    logic                    all_free;
    logic [8:0]              conv;

    // Returns {clamped, s8 result} for one sample after the arithmetic shift.
    function automatic logic [8:0] sat8(input logic signed [15:0] s);
        logic signed [15:0] t;
        t = s >>> SHIFT;
        if (t > 16'sd127)
            return {1'b1, 8'h7F};
        else if (t < -16'sd128)
            return {1'b1, 8'h80};
        else
            return {1'b0, t[7:0]};
    endfunction

    assign m_rdy     = {m21_axis_tready, m20_axis_tready, m01_axis_tready, m00_axis_tready};
    assign beat_acc  = s_axis_mm2s_tvalid & s_ready_q;
    assign word_done = beat_acc & ((cnt == 2'd3) | s_axis_mm2s_tlast);
    assign all_free  = ~|hold_vld;

    // Current pack contents with this beat merged into lanes 4*cnt .. 4*cnt+3.
    always_comb begin
        conv     = '0;
        keep_new = '0;
        sat_hit  = '0;
        for (int c = 0; c < NCH; c++) begin
            word[c] = pack[c];
            for (int l = 0; l < LANES; l++) begin
                if (l / 4 == int'(cnt)) begin
                    // lane j of this group comes from input sample c + 4*j
                    conv = sat8(s_axis_mm2s_tdata[16*(c + 4*(l % 4)) +: 16]);
                    word[c][8*l +: 8] = conv[7:0];
                    sat_hit[c] = sat_hit[c] | conv[8];
                end
            end
        end
        for (int l = 0; l < LANES; l++)
            keep_new[l] = (l < 4 * (int'(cnt) + 1));
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state     <= ST_FILL;
            s_ready_q <= 1'b0;
            cnt       <= '0;
            sat_flag  <= '0;
            pend_keep <= '0;
            pend_last <= 1'b0;
            hold_vld  <= '0;
            for (int c = 0; c < NCH; c++) begin
                pack[c]      <= '0;
                hold_dat[c]  <= '0;
                hold_keep[c] <= '0;
                hold_last[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (hold_vld[c] && m_rdy[c])
                    hold_vld[c] <= 1'b0;
                if (sat_clear)
                    sat_flag[c] <= 1'b0;
                else if (beat_acc && sat_hit[c])
                    sat_flag[c] <= 1'b1;
            end

            case (state)
                ST_FILL: begin
                    s_ready_q <= 1'b1;
                    if (beat_acc) begin
                        if (word_done) begin
                            cnt <= '0;
                            if (all_free) begin
                                for (int c = 0; c < NCH; c++) begin
                                    hold_dat[c]  <= word[c];
                                    hold_keep[c] <= keep_new;
                                    hold_last[c] <= s_axis_mm2s_tlast;
                                    hold_vld[c]  <= 1'b1;
                                    pack[c]      <= '0;
                                end
                            end else begin
                                // Park the finished word in the pack registers until every output drains.
                                for (int c = 0; c < NCH; c++)
                                    pack[c] <= word[c];
                                pend_keep <= keep_new;
                                pend_last <= s_axis_mm2s_tlast;
                                state     <= ST_WAIT;
                                s_ready_q <= 1'b0;
                            end
                        end else begin
                            for (int c = 0; c < NCH; c++)
                                pack[c] <= word[c];
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (all_free) begin
                        for (int c = 0; c < NCH; c++) begin
                            hold_dat[c]  <= pack[c];
                            hold_keep[c] <= pend_keep;
                            hold_last[c] <= pend_last;
                            hold_vld[c]  <= 1'b1;
                            pack[c]      <= '0;
                        end
                        state     <= ST_FILL;
                        s_ready_q <= 1'b1;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    assign s_axis_mm2s_tready = s_ready_q;

    assign m00_axis_tdata  = hold_dat[0];
    assign m00_axis_tkeep  = hold_keep[0];
    assign m00_axis_tlast  = hold_last[0];
    assign m00_axis_tvalid = hold_vld[0];

    assign m01_axis_tdata  = hold_dat[1];
    assign m01_axis_tkeep  = hold_keep[1];
    assign m01_axis_tlast  = hold_last[1];
    assign m01_axis_tvalid = hold_vld[1];

    assign m20_axis_tdata  = hold_dat[2];
    assign m20_axis_tkeep  = hold_keep[2];
    assign m20_axis_tlast  = hold_last[2];
    assign m20_axis_tvalid = hold_vld[2];

    assign m21_axis_tdata  = hold_dat[3];
    assign m21_axis_tkeep  = hold_keep[3];
    assign m21_axis_tlast  = hold_last[3];
    assign m21_axis_tvalid = hold_vld[3];

endmodule
